noc_port_arbiter: RTL and testbench

NOC_PORT_ARBITER -- requirements
Module: noc_port_arbiter

---
 rtl/noc_pkg.sv | 14 +
 rtl/sm_rr_pick.sv | 31 +++
 rtl/noc_port_arbiter.sv | 118 +++++++++++
 tb/tb_noc_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: port geometry and the arbiter state encoding,
// used by both the port arbiter and the router.
package noc_pkg;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 128;
    localparam int ID_W   = $clog2(N_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sm_rr_pick.sv
// Combinational round-robin search: first set request bit starting at ptr,
// wrapping modulo N.
module sm_rr_pick
    import noc_pkg::*;
#(
    parameter int N = N_REQ,
    parameter int W = ID_W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // Walk ptr, ptr+1, ... and keep the first hit; later hits are ignored.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Packet-level round-robin arbiter merging N_REQ core flit streams into one
// registered router input port; a grant is held until the owner's last flit.
module noc_port_arbiter #(
    parameter int N_REQ  = noc_pkg::N_REQ,
    parameter int DATA_W = noc_pkg::DATA_W,
    parameter int ID_W   = noc_pkg::ID_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    output logic [ID_W-1:0]         out_src,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [ID_W-1:0]         owner
);

    import noc_pkg::arb_state_t;
    import noc_pkg::IDLE;
    import noc_pkg::BUSY;

    arb_state_t        state;
    arb_state_t        state_next;
    logic [ID_W-1:0]   owner_q;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   ptr_after_owner;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              can_take;
    logic              xfer;
    logic              owner_valid;
    logic              owner_last;
    logic [DATA_W-1:0] owner_data;

    sm_rr_pick #(
        .N (N_REQ),
        .W (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_valid     = req_valid[owner_q];
    assign owner_last      = req_last[owner_q];
    assign owner_data      = req_data[int'(owner_q)*DATA_W +: DATA_W];
    assign ptr_after_owner = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    // The owner may push whenever the output register is empty or draining.
    assign can_take = (state == BUSY) && (!out_valid || out_ready) && !rst;
    assign xfer     = can_take && owner_valid;

    always_comb begin
        req_ready = '0;
        if (can_take) begin
            req_ready[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found)         state_next = BUSY;
            BUSY:    if (xfer && owner_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant holder is latched on arbitration; the pointer moves past it
    // only once its packet has fully gone through.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= '0;
            rr_ptr  <= '0;
        end else begin
            if (state == IDLE && pick_found) begin
                owner_q <= pick_idx;
            end
            if (xfer && owner_last) begin
                rr_ptr <= ptr_after_owner;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= owner_data;
            out_last  <= owner_last;
            out_src   <= owner_q;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy  = (state == BUSY);
    assign owner = owner_q;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Self-checking bench for noc_port_arbiter: directed scenarios plus random
// traffic compared cycle by cycle against a packet-level reference model.
module tb_noc_port_arbiter;

    import noc_pkg::*;

    localparam int N  = N_REQ;
    localparam int DW = DATA_W;
    localparam int IW = ID_W;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] src;
    } flit_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [IW-1:0]   out_src;
    logic            out_ready;
    logic            busy;
    logic [IW-1:0]   owner;

    always #5 clk = ~clk;

    noc_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy),
        .owner     (owner)
    );

    int vec_count = 0;
    int err_count = 0;

    // Core-side traffic generators
    int            remaining [N];
    int            auto_len  [N];
    logic [DW-1:0] cur_data  [N];
    bit            en        [N];
    bit            rand_mode;

    // Reference model: grant flag/holder, pointer and an output queue
    bit            m_busy;
    logic [IW-1:0] m_owner;
    int            m_ptr;
    flit_t         m_pipe[$];

    int grants[$];
    bit prev_busy;
    int dut_acc [N];

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v = '0;
        for (int w = 0; w < DW; w += 32) begin
            v = {v[DW-33:0], 32'($urandom)};
        end
        return v;
    endfunction

    task automatic start_packet(input int i, input int len);
        remaining[i] = len;
        cur_data[i]  = rand_data();
        en[i]        = 1'b1;
    endtask

    task automatic clear_gen();
        for (int i = 0; i < N; i++) begin
            remaining[i] = 0;
            auto_len[i]  = 0;
            en[i]        = 1'b0;
            dut_acc[i]   = 0;
        end
    endtask

    task automatic applyStimulus();
        if (rand_mode) begin
            rst       = ($urandom_range(199) == 0);
            out_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) begin
                en[i] = ($urandom_range(3) != 0);
                if (remaining[i] == 0 && $urandom_range(2) == 0) begin
                    start_packet(i, 1 + $urandom_range(3));
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = en[i] && (remaining[i] > 0);
            req_last[i]            = (remaining[i] == 1);
            req_data[i*DW +: DW]   = cur_data[i];
        end
    endtask

    // Re-drive the (deterministic) inputs and let outputs settle before sampling.
    task automatic peek();
        applyStimulus();
        #1;
    endtask

    // One clock cycle: check every output against the model, advance the model.
    task automatic step();
        logic [N-1:0] exp_ready;
        bit           take;
        int           best;
        logic [IW-1:0] win;
        applyStimulus();
        #1;
        exp_ready = '0;
        if (!rst && m_busy && (m_pipe.size() == 0 || out_ready)) exp_ready[m_owner] = 1'b1;
        checkOutput("req_ready", DW'(req_ready), DW'(exp_ready));
        checkOutput("busy", DW'(busy), DW'(m_busy));
        checkOutput("owner", DW'(owner), DW'(m_owner));
        checkOutput("out_valid", DW'(out_valid), DW'(m_pipe.size() != 0));
        if (m_pipe.size() != 0) begin
            checkOutput("out_data", out_data, m_pipe[0].data);
            checkOutput("out_last", DW'(out_last), DW'(m_pipe[0].last));
            checkOutput("out_src", DW'(out_src), DW'(m_pipe[0].src));
        end
        if (busy && !prev_busy) grants.push_back(int'(owner));
        prev_busy = busy;
        if (out_valid && out_ready && !rst) dut_acc[out_src]++;

        if (rst) begin
            m_busy    = 1'b0;
            m_owner   = '0;
            m_ptr     = 0;
            prev_busy = 1'b0;
            m_pipe.delete();
        end else begin
            take = m_busy && exp_ready[m_owner] && req_valid[m_owner];
            if (m_pipe.size() != 0 && out_ready) void'(m_pipe.pop_front());
            if (take) begin
                m_pipe.push_back('{data: cur_data[m_owner], last: req_last[m_owner], src: m_owner});
                remaining[m_owner]--;
                cur_data[m_owner] = rand_data();
                if (req_last[m_owner]) begin
                    m_busy = 1'b0;
                    m_ptr  = (int'(m_owner) + 1) % N;
                    if (auto_len[m_owner] > 0) start_packet(int'(m_owner), auto_len[m_owner]);
                end
            end else if (!m_busy && (|req_valid)) begin
                // Winner is the requester at the smallest forward distance from the pointer.
                best = N;
                win  = '0;
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && ((i - m_ptr + N) % N) < best) begin
                        best = (i - m_ptr + N) % N;
                        win  = IW'(i);
                    end
                end
                m_busy  = 1'b1;
                m_owner = win;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_gen();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        grants.delete();
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step();
    endtask

    function automatic int grant_at(input int k);
        return (k < grants.size()) ? grants[k] : -1;
    endfunction

    initial begin
        int first_v, first_r, n_src2, first_o, last_o, last_at, idle_run;
        bit seen_busy, seen;
        logic [DW-1:0] held;
        int exp_order [5] = '{0, 1, 2, 3, 0};

        rst       = 1'b1;
        out_ready = 1'b1;
        rand_mode = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        m_busy    = 1'b0;
        m_owner   = '0;
        m_ptr     = 0;
        prev_busy = 1'b0;
        clear_gen();
        @(negedge clk);

        // Reset state and single 3-flit packet from core 2
        do_reset();
        checkOutput("rst_out_data", out_data, '0);
        checkOutput("rst_out_last", DW'(out_last), '0);
        checkOutput("rst_out_src", DW'(out_src), '0);
        first_v = -1; first_r = -1; n_src2 = 0; first_o = -1; last_o = -1; last_at = -1;
        start_packet(2, 3);
        for (int c = 0; c < 10; c++) begin
            peek();
            if (req_valid[2] && first_v < 0) first_v = c;
            if (req_ready[2] && first_r < 0) first_r = c;
            if (out_valid && out_src == 2) begin
                n_src2++;
                if (first_o < 0) first_o = c;
                last_o = c;
                if (out_last) last_at = n_src2;
            end
            step();
        end
        peek();
        checkOutput("s1_ready_latency", DW'(first_r - first_v), DW'(1));
        checkOutput("s1_flit_count", DW'(n_src2), DW'(3));
        checkOutput("s1_consecutive", DW'(last_o - first_o), DW'(2));
        checkOutput("s1_last_on_third", DW'(last_at), DW'(3));
        checkOutput("s1_busy_end", DW'(busy), '0);

        // All four cores continuously sending 2-flit packets
        do_reset();
        for (int i = 0; i < N; i++) begin
            auto_len[i] = 2;
            start_packet(i, 2);
        end
        seen_busy = 1'b0;
        idle_run  = 0;
        for (int c = 0; c < 17; c++) begin
            peek();
            if (busy) begin
                if (seen_busy && idle_run > 0) checkOutput("s2_dead_cycles", DW'(idle_run), DW'(1));
                seen_busy = 1'b1;
                idle_run  = 0;
            end else begin
                idle_run++;
            end
            step();
        end
        checkOutput("s2_grant_count_ok", DW'(grants.size() >= 5), DW'(1));
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("s2_grant%0d", k), DW'(grant_at(k)), DW'(exp_order[k]));
        end

        // Backpressure for 5 cycles in the middle of a 4-flit packet
        do_reset();
        start_packet(1, 4);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            peek();
            if (out_valid) seen = 1'b1;
            else step();
        end
        checkOutput("s3_out_seen", DW'(seen), DW'(1));
        held      = out_data;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            peek();
            checkOutput("s3_data_hold", out_data, held);
            checkOutput("s3_ready_low", DW'(req_ready[1]), '0);
            step();
        end
        out_ready = 1'b1;
        run(10);
        checkOutput("s3_accepted", DW'(dut_acc[1]), DW'(4));

        // Pointer wrap: after core 3, cores 0 and 3 compete
        do_reset();
        start_packet(3, 1);
        run(6);
        grants.delete();
        start_packet(0, 2);
        start_packet(3, 2);
        run(8);
        checkOutput("s4_wrap_grant", DW'(grant_at(0)), DW'(0));

        // Owner bubble: core 1 pauses mid-packet while core 0 waits
        do_reset();
        start_packet(1, 3);
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            peek();
            if (req_ready[1] && req_valid[1]) seen = 1'b1;
            step();
        end
        checkOutput("s5_first_xfer", DW'(seen), DW'(1));
        en[1] = 1'b0;
        start_packet(0, 1);
        for (int c = 0; c < 2; c++) begin
            peek();
            checkOutput("s5_owner_hold", DW'(owner), DW'(1));
            checkOutput("s5_busy_hold", DW'(busy), DW'(1));
            step();
        end
        en[1] = 1'b1;
        run(12);
        checkOutput("s5_grant0", DW'(grant_at(0)), DW'(1));
        checkOutput("s5_grant1", DW'(grant_at(1)), DW'(0));
        checkOutput("s5_core1_flits", DW'(dut_acc[1]), DW'(3));

        // Reset during the second flit of a packet
        do_reset();
        start_packet(2, 3);
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            peek();
            if (req_ready[2] && req_valid[2]) seen = 1'b1;
            step();
        end
        peek();
        checkOutput("s6_second_flit_ready", DW'(req_ready[2]), DW'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_gen();
        peek();
        checkOutput("s6_out_valid_cleared", DW'(out_valid), '0);
        checkOutput("s6_busy_cleared", DW'(busy), '0);
        grants.delete();
        start_packet(3, 1);
        start_packet(1, 1);
        run(6);
        checkOutput("s6_grant_after_reset", DW'(grant_at(0)), DW'(1));

        // Random traffic, random backpressure and occasional reset
        do_reset();
        rand_mode = 1'b1;
        run(600);
        rand_mode = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        run(60);
        peek();
        checkOutput("rand_drained_busy", DW'(busy), '0);
        checkOutput("rand_drained_valid", DW'(out_valid), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
